// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word fall-through byte FIFO
module uart_rx_fifo #(
  parameter int FREQ_MAIN_HZ        = 12000000,
  parameter int FREQ_TARGET_UART_HZ = 9600,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       rx_available,
  output logic [7:0] rx_data,
  input  logic       rx_data_ack,
  output logic       rx_overflow,
  output logic       rx_frame_error
);

  localparam int CLKS_PER_BIT = FREQ_MAIN_HZ / FREQ_TARGET_UART_HZ;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PW           = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [PW-1:0] FULL_CNT  = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rx_sync;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   count;
  logic [PW-1:0]   count_next;

  logic            stop_done;
  logic            push_req;
  logic            full;
  logic            pop;
  logic            push;

  assign stop_done = (state == STOP) && (bit_cnt == BIT_LAST);
  assign push_req  = stop_done && rx_sync;
  assign full      = (count == FULL_CNT);
  assign pop       = rx_data_ack && (count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
  assign push      = push_req && (!full || pop);

  // Head byte comes straight from the storage array; zero when the FIFO is empty.
  assign rx_data   = (count != '0) ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame deserializer: start validation, 8 data bits LSB first, stop check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      rx_frame_error <= 1'b0;
    end else begin
      rx_frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            // A line back high at mid start bit was only a glitch.
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt        <= '0;
            shift[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              rx_frame_error <= 1'b1;
              state          <= WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a break is not read as 0x00 frames.
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers, occupancy, availability flag and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rx_available <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      rx_available <= (count_next != '0);
      rx_overflow  <= push_req && !push;
    end
  end

  // Byte storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shift;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int MAIN = 160;
  localparam int BAUD = 10;
  localparam int CPB  = MAIN / BAUD;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_available;
  logic [7:0] rx_data;
  logic       rx_data_ack;
  logic       rx_overflow;
  logic       rx_frame_error;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int fall_cyc = 0;
  int rise_cyc = -1;
  int ovf_hi = 0, ovf_rise = 0, fe_hi = 0, fe_rise = 0;
  logic avail_q = 1'b0, ovf_q = 1'b0, fe_q = 1'b0;

  uart_rx_fifo #(
    .FREQ_MAIN_HZ(MAIN),
    .FREQ_TARGET_UART_HZ(BAUD),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .rx_available(rx_available),
    .rx_data(rx_data),
    .rx_data_ack(rx_data_ack),
    .rx_overflow(rx_overflow),
    .rx_frame_error(rx_frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_available && !avail_q) rise_cyc = cyc;
    if (rx_overflow) ovf_hi++;
    if (rx_overflow && !ovf_q) ovf_rise++;
    if (rx_frame_error) fe_hi++;
    if (rx_frame_error && !fe_q) fe_rise++;
    avail_q = rx_available;
    ovf_q   = rx_overflow;
    fe_q    = rx_frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_stop);
    fall_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    uart_rx = stop_bit;
    for (int c = 0; c < CPB; c++) begin
      rx_data_ack = ack_stop && (cyc == fall_cyc + 2 + HALF + 9 * CPB);
      @(posedge clk);
      #1;
    end
    rx_data_ack = 1'b0;
    uart_rx = 1'b1;
  endtask

  task automatic pop_one();
    rx_data_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ack = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    uart_rx = 1'b1;
    rx_data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_avail", rx_available, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_ovf", rx_overflow, 0);
    check("reset_fe", rx_frame_error, 0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // Single byte and its latency.
    send_frame(8'h41, 1'b1, 1'b0);
    lat = rise_cyc - fall_cyc;
    check("latency_in_window", (lat >= HALF + 9 * CPB + 2) && (lat <= HALF + 9 * CPB + 5), 1);
    check("a_avail", rx_available, 1);
    check("a_data", rx_data, 8'h41);
    pop_one();
    @(negedge clk);
    check("a_popped", rx_available, 0);
    check("a_data_empty", rx_data, 8'h00);
    hold(1'b1, CPB);

    // Nine back-to-back bytes: the ninth overflows.
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovf_none_before_9th", ovf_rise, 0);
    send_frame(8'h08, 1'b1, 1'b0);
    hold(1'b1, CPB);
    check("ovf_pulses", ovf_rise, 1);
    check("ovf_width", ovf_hi, 1);
    for (int i = 0; i < 8; i++) begin
      check("fill_avail", rx_available, 1);
      check("fill_order", rx_data, i);
      pop_one();
    end
    check("fill_drained", rx_available, 0);

    // Short low glitch on an idle line.
    hold(1'b0, HALF / 2);
    hold(1'b1, 2 * CPB);
    check("glitch_no_push", rx_available, 0);
    check("glitch_no_fe", fe_rise, 0);

    // Bad stop bit, break, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0);
    hold(1'b0, 3 * CPB);
    hold(1'b1, CPB);
    check("fe_pulses", fe_rise, 1);
    check("fe_width", fe_hi, 1);
    check("fe_no_push", rx_available, 0);
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, CPB);
    check("a5_avail", rx_available, 1);
    check("a5_data", rx_data, 8'hA5);
    check("fe_no_repeat", fe_rise, 1);
    pop_one();
    check("a5_popped", rx_available, 0);

    // Full FIFO with a pop coinciding with the push.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    send_frame(8'h99, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("full_pop_no_ovf", ovf_rise, 1);
    for (int i = 1; i < 8; i++) begin
      check("full_order", rx_data, 8'h10 + i);
      pop_one();
    end
    check("full_last_99", rx_data, 8'h99);
    pop_one();
    check("full_drained", rx_available, 0);

    // Reset in the middle of a frame.
    send_frame(8'h77, 1'b1, 1'b0);
    hold(1'b1, CPB);
    check("pre_rst_avail", rx_available, 1);
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(logic'((8'h3C >> i) & 8'h01), CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    #1;
    check("rst_avail_now", rx_available, 0);
    check("rst_data_now", rx_data, 8'h00);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    check("post_rst_idle", rx_available, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, CPB);
    check("post_rst_avail", rx_available, 1);
    check("post_rst_data", rx_data, 8'h3C);
    pop_one();
    check("post_rst_drained", rx_available, 0);
    check("final_fe", fe_rise, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
